// File: rtl/contador_preset.sv
// Two-digit BCD countdown timer: loads a unit/tens preset and counts down to 00
// once every DIV clock cycles. Define CONTADOR_PAUSA_EN to add the pausa input.
module contador_preset #(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] unid_preset,
  input  logic [1:0] dez_preset,
  input  logic       carregar,
`ifdef CONTADOR_PAUSA_EN
  input  logic       pausa,
`endif
  output logic [3:0] unid,
  output logic [1:0] dez,
  output logic       ocupado,
  output logic       zero,
  output logic       fim
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {OCIOSO, CONTANDO, FIM} estado_t;

  estado_t       estado, prox_estado;
  logic [PW-1:0] presc;
  logic [3:0]    unid_carga, unid_dec;
  logic [1:0]    dez_dec;
  logic          carga_zero, chega_zero, corre, tick;

`ifdef CONTADOR_PAUSA_EN
  assign corre = ~pausa;
`else
  assign corre = 1'b1;
`endif

  // NOTE: every signal driven in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    unid_carga = (unid_preset > 4'd9) ? 4'd9 : unid_preset;
    carga_zero = (unid_carga == 4'd0) && (dez_preset == 2'd0);
    tick       = (estado == CONTANDO) && corre && (presc == PW'(DIV - 1));
    unid_dec   = unid - 4'd1;
    dez_dec    = dez;
    if (unid == 4'd0) begin
      unid_dec = 4'd9;
      dez_dec  = dez - 2'd1;
    end
    chega_zero = (unid_dec == 4'd0) && (dez_dec == 2'd0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox_estado;
  end

  // A load overrides everything, including a tick landing in the same cycle.
  always_comb begin
    prox_estado = estado;
    if (carregar) begin
      prox_estado = carga_zero ? FIM : CONTANDO;
    end else begin
      case (estado)
        CONTANDO: if (tick && chega_zero) prox_estado = FIM;
        default:  prox_estado = estado;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unid  <= 4'd0;
      dez   <= 2'd0;
      presc <= '0;
      fim   <= 1'b0;
    end else begin
      fim <= 1'b0;
      if (carregar) begin
        unid  <= unid_carga;
        dez   <= dez_preset;
        presc <= '0;
        fim   <= carga_zero;
      end else if (estado == CONTANDO && corre) begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) begin
          unid <= unid_dec;
          dez  <= dez_dec;
          fim  <= chega_zero;
        end
      end
    end
  end

  always_comb begin
    ocupado = (estado == CONTANDO);
    zero    = (estado == FIM);
  end

endmodule
